// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin arbiter and sequencer that shares a single
// WIDTH-bit Booth multiplier among N_REQ requesters. A granted requester's X/Y
// operands are fed to the multiplier (X on the start cycle, Y one cycle later),
// the product is read back as {hi, lo} halves on consecutive cycles, and it is
// returned with a one-hot rsp_valid pulse to the owner.
//
// Optional feature: define ARB_TIMEOUT_EN to abort an operation that waits
// TIMEOUT cycles without mul_done (resets the multiplier, answers with rsp_err).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req             request lines, held until the matching gnt bit
//   x_in, y_in      packed operands, requester i in [i*WIDTH +: WIDTH]
//   gnt             one-hot grant pulse, operands sampled in that cycle
//   rsp_valid       one-hot response pulse to the owner
//   rsp_prod        product {hi, lo}, valid with rsp_valid
//   rsp_err         abort flag, valid with rsp_valid
//   busy            high in every state except IDLE
//   mul_rst         multiplier reset (rst or abort pulse)
//   mul_start       multiplier start pulse
//   mul_in_bus      multiplier operand bus
//   mul_done        multiplier done
//   mul_out_bus     multiplier result bus
module booth_mult_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] x_in,
  input  logic [N_REQ*WIDTH-1:0] y_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [2*WIDTH-1:0]     rsp_prod,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   mul_rst,
  output logic                   mul_start,
  output logic [WIDTH-1:0]       mul_in_bus,
  input  logic                   mul_done,
  input  logic [WIDTH-1:0]       mul_out_bus
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  // Parameter sanity checks at elaboration.
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("N_REQ must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, START, LOAD_Y, WAIT, READ_LO, RESP} state_t;

  state_t                 state, next_state;
  logic [PTR_W-1:0]       ptr, ptr_d, winner, cand;
  logic                   found;
  logic [N_REQ-1:0]       grant_c, valid_d;
  logic [WIDTH-1:0]       y_q, y_d, hi_q, hi_d, bus_d;
  logic [2*WIDTH-1:0]     prod_d;
  logic                   start_d, busy_d;
  logic [WIDTH-1:0]       x_arr [N_REQ];
  logic [WIDTH-1:0]       y_arr [N_REQ];

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_d, abort;
`endif

  // Unpack the operand buses per requester.
  for (genvar g = 0; g < int'(N_REQ); g++) begin : g_unpack
    assign x_arr[g] = x_in[g*WIDTH +: WIDTH];
    assign y_arr[g] = y_in[g*WIDTH +: WIDTH];
  end

  // Round-robin pick: first active request after ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    cand   = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand = PTR_W'((int'(ptr) + k) % int'(N_REQ));
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state, datapath updates and next values of the registered outputs.
  always_comb begin
    next_state = state;
    grant_c    = '0;
    ptr_d      = ptr;
    y_d        = y_q;
    hi_d       = hi_q;
    bus_d      = '0;
    start_d    = 1'b0;
    valid_d    = '0;
    prod_d     = '0;
`ifdef ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    abort      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          grant_c    = ONE_HOT0 << winner;
          ptr_d      = winner;
          y_d        = y_arr[winner];
          bus_d      = x_arr[winner];
          start_d    = 1'b1;
          next_state = START;
        end
      end
      START: begin
        bus_d      = y_q;
        next_state = LOAD_Y;
      end
      LOAD_Y: begin
`ifdef ARB_TIMEOUT_EN
        cnt_d      = '0;
`endif
        next_state = WAIT;
      end
      WAIT: begin
        // Done has priority over an expiring timeout in the same cycle.
        if (mul_done) begin
          hi_d       = mul_out_bus;
          next_state = READ_LO;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          abort      = 1'b1;
          err_d      = 1'b1;
          valid_d    = ONE_HOT0 << ptr;
          next_state = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      READ_LO: begin
        valid_d    = ONE_HOT0 << ptr;
        prod_d     = {hi_q, mul_out_bus};
        next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    busy_d = (next_state != IDLE);
  end

  // Datapath and registered outputs; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= PTR_W'(N_REQ - 1);
      y_q        <= '0;
      hi_q       <= '0;
      busy       <= 1'b0;
      mul_start  <= 1'b0;
      mul_in_bus <= '0;
      rsp_valid  <= '0;
      rsp_prod   <= '0;
`ifdef ARB_TIMEOUT_EN
      rsp_err    <= 1'b0;
      cnt_q      <= '0;
`endif
    end else begin
      ptr        <= ptr_d;
      y_q        <= y_d;
      hi_q       <= hi_d;
      busy       <= busy_d;
      mul_start  <= start_d;
      mul_in_bus <= bus_d;
      rsp_valid  <= valid_d;
      rsp_prod   <= prod_d;
`ifdef ARB_TIMEOUT_EN
      rsp_err    <= err_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Grant must be seen in the IDLE cycle itself, so it is decoded directly.
  assign gnt = rst ? '0 : grant_c;

`ifdef ARB_TIMEOUT_EN
  assign mul_rst = rst | abort;
`else
  assign mul_rst = rst;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/booth_mult_arbiter.md
# booth_mult_arbiter

Round-robin arbiter and sequencer that shares one 6-bit Booth multiplier (start/done handshake, shared 6-bit input and output buses) among N_REQ requesters. Each requester presents signed operands X and Y. The block grants one requester at a time, drives the multiplier's start/load sequence, collects the 12-bit product as two 6-bit halves, and returns it with a one-hot valid pulse. It sits between client FSMs and the multiplier top level.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- WIDTH, 6: operand width; must match the multiplier bus width.
- TIMEOUT, 64: maximum WAIT cycles before abort. Used only with ARB_TIMEOUT_EN.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  request lines; held high until the matching gnt bit.
- x_in  in  N_REQ*WIDTH  packed X operands; requester i in bits [i*WIDTH +: WIDTH].
- y_in  in  N_REQ*WIDTH  packed Y operands, same packing.
- gnt  out  N_REQ  one-hot, 1-cycle pulse; operands sampled on this cycle.
- rsp_valid  out  N_REQ  one-hot, 1-cycle pulse to the owner when a result is ready.
- rsp_prod  out  2*WIDTH  product {hi, lo}; valid only while a rsp_valid bit is high.
- rsp_err  out  1  high with rsp_valid when the operation was aborted.
- busy  out  1  high in every state except IDLE.
- mul_rst  out  1  multiplier reset; equals rst OR abort pulse.
- mul_start  out  1  multiplier start pulse.
- mul_in_bus  out  WIDTH  multiplier input bus.
- mul_done  in  1  multiplier done.
- mul_out_bus  in  WIDTH  multiplier output bus.

## Operation
- Multiplier bus contract:
  - X is on the input bus in the mul_start cycle; Y is on the bus the following cycle.
  - In the first mul_done cycle, the output bus carries product[11:6].
  - The next cycle, it carries product[5:0].
- States: IDLE, START, LOAD_Y, WAIT, READ_LO, RESP.
- IDLE: if any req bit is set, pick the winner by round-robin.
  - Search starts at ptr+1 mod N_REQ.
  - Assert gnt[winner], latch x/y into internal registers, set ptr := winner, go to START.
  - If no req bit is set, stay in IDLE.
- START: mul_start=1, mul_in_bus=X. Go to LOAD_Y.
- LOAD_Y: mul_in_bus=Y. Go to WAIT.
- WAIT: mul_in_bus=0.
  - When mul_done=1, latch hi := mul_out_bus and go to READ_LO.
  - Otherwise stay in WAIT.
- READ_LO: latch lo := mul_out_bus. Go to RESP.
- RESP: rsp_valid[owner]=1, rsp_prod={hi,lo}, rsp_err=0. Go to IDLE.
- Outside its defined states, each output is 0: mul_in_bus, rsp_prod, gnt, rsp_valid, mul_start.
- No arithmetic is done here. The product is passed through unchanged as a two's-complement 2*WIDTH value.
- A req that is still high in IDLE after RESP is a new request. It competes normally and has lowest priority, because ptr now points at that requester.
- A req that drops before gnt is forgotten; no state is kept.

## Timing
- Reset (synchronous):
  - State goes to IDLE and ptr := N_REQ-1, so requester 0 wins first.
  - These outputs are 0 from the first clock edge with rst high: gnt, rsp_valid, rsp_prod, rsp_err, busy, mul_start, mul_in_bus.
  - mul_rst is 1 while rst is high.
- rst during any state aborts silently: no rsp_valid, and the latched operands are discarded.
- Cycle sequence, with gnt in cycle t:
  - mul_start in t+1.
  - Y on the bus in t+2.
  - WAIT from t+3.
  - If mul_done is first seen in cycle d: lo latched in d+1, rsp_valid in d+2.
- Minimum gap between gnt pulses is 6 cycles. The next gnt can come in the cycle after RESP.
- mul_done high in START or LOAD_Y is ignored.
- Simultaneous req on every line: grants rotate 0,1,2,3,0,…
- busy is high from the cycle after gnt through the RESP cycle, inclusive.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter is cleared on entry to WAIT and incremented each WAIT cycle.
  - If it reaches TIMEOUT without mul_done, the block pulses mul_rst for 1 cycle and goes to RESP.
  - In that RESP cycle: rsp_err=1, rsp_prod=0, rsp_valid[owner]=1.
  - mul_done in the same cycle as the counter reaching TIMEOUT counts as a success; done wins.
- ARB_TIMEOUT_EN undefined:
  - No counter is built, and WAIT lasts until mul_done.
  - rsp_err is tied to 0 and mul_rst = rst.

## Test plan
- Reset, then only req[0] with X=6'd3, Y=6'd5, and a model multiplier with done after 7 cycles:
  - gnt[0] in cycle t, mul_start in t+1 with bus=3, bus=5 in t+2.
  - rsp_valid[0] with rsp_prod=12'd15.
- Signed operands: X=6'b111110 (-2), Y=6'd31 -> rsp_prod=12'hFC2 (-62), rsp_err=0.
- All four req bits held high across 8 operations -> gnt order 0,1,2,3,0,1,2,3, with each gnt ≥6 cycles apart.
- rst asserted in WAIT:
  - IDLE on the next edge, all outputs 0, no rsp_valid.
  - The next grant goes to requester 0.
- With ARB_TIMEOUT_EN and TIMEOUT=10, mul_done never asserted:
  - mul_rst pulses once, then rsp_valid[owner] with rsp_err=1 and rsp_prod=0.
  - busy drops the following cycle.
- mul_done asserted in the LOAD_Y cycle and again 3 cycles later -> the first pulse is ignored, and hi is latched from the second.
